// File: rtl/pump_scheduler.sv
// Filter pump scheduler: soft-start ramping, restart holdoff, PWM clamping and a shared
// duty budget with pump A priority. Define PUMP_WDOG_EN to add the on-time watchdog and fault port.

module pump_channel #(
    parameter logic [7:0] RAMP_STEP      = 8'd4,
    parameter int         MIN_OFF_CYCLES = 50_000_000,
    parameter logic [7:0] PWM_MIN        = 8'd77
`ifdef PUMP_WDOG_EN
    , parameter logic [31:0] WDOG_CYCLES = 32'd2_500_000_000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] target,
    input  logic       cut,
    input  logic [7:0] duty,
    output logic [7:0] duty_next,
    output logic       running
`ifdef PUMP_WDOG_EN
    , output logic     trip
`endif
);

    localparam int HOLD_W = (MIN_OFF_CYCLES > 1) ? $clog2(MIN_OFF_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_OFF_CYCLES - 1);

    typedef enum logic [1:0] {OFF, RAMP, RUN, HOLDOFF} state_t;

    state_t            state, state_next;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;

    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            step_toward = cur + ((diff > RAMP_STEP) ? RAMP_STEP : diff);
        end else begin
            diff = cur - tgt;
            step_toward = cur - ((diff > RAMP_STEP) ? RAMP_STEP : diff);
        end
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= OFF;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // A budget cut (cut=1 with duty above target) bypasses the ramp so the sum limit holds every cycle.
    always_comb begin
        state_next    = state;
        duty_next     = duty;
        hold_cnt_next = '0;
        case (state)
            OFF: begin
                duty_next = 8'd0;
                if (target != 8'd0) begin
                    state_next = RAMP;
                    duty_next  = PWM_MIN;
                end
            end
            RAMP: begin
                if (target == 8'd0) begin
                    state_next = HOLDOFF;
                    duty_next  = 8'd0;
                end else if (cut && (duty > target)) begin
                    state_next = RUN;
                    duty_next  = target;
                end else if (duty == target) begin
                    state_next = RUN;
                end else if (tick) begin
                    duty_next = step_toward(duty, target);
                    if (duty_next == target)
                        state_next = RUN;
                end
            end
            RUN: begin
                if (target == 8'd0) begin
                    state_next = HOLDOFF;
                    duty_next  = 8'd0;
                end else if (cut && (duty > target)) begin
                    duty_next = target;
                end else if (target != duty) begin
                    state_next = RAMP;
                end
            end
            HOLDOFF: begin
                duty_next = 8'd0;
                if (hold_cnt == HOLD_LAST)
                    state_next = OFF;
                else
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
            end
            default: begin
                state_next = OFF;
                duty_next  = 8'd0;
            end
        endcase
`ifdef PUMP_WDOG_EN
        if (trip) begin
            state_next    = HOLDOFF;
            duty_next     = 8'd0;
            hold_cnt_next = '0;
        end
`endif
    end

    assign running = (state == RUN);

`ifdef PUMP_WDOG_EN
    logic [31:0] on_cnt;
    logic        active_next;

    assign trip        = ((state == RAMP) || (state == RUN)) && (on_cnt == WDOG_CYCLES - 32'd1);
    assign active_next = (state_next == RAMP) || (state_next == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            on_cnt <= 32'd0;
        else
            on_cnt <= active_next ? on_cnt + 32'd1 : 32'd0;
    end
`endif

endmodule

module pump_scheduler #(
    parameter int         RAMP_DIV       = 500_000,
    parameter logic [7:0] RAMP_STEP      = 8'd4,
    parameter int         MIN_OFF_CYCLES = 50_000_000,
    parameter logic [7:0] PWM_MIN        = 8'd77,
    parameter logic [7:0] PWM_MAX        = 8'd230,
    parameter logic [8:0] BUDGET         = 9'd400
`ifdef PUMP_WDOG_EN
    , parameter logic [31:0] WDOG_CYCLES = 32'd2_500_000_000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] req_duty_a,
    input  logic [7:0] req_duty_b,
    output logic [7:0] duty_a,
    output logic [7:0] duty_b,
    output logic       running_a,
    output logic       running_b,
    output logic       clipped_b
`ifdef PUMP_WDOG_EN
    , output logic     fault
`endif
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             permit;
    logic [7:0]       target_a, target_b_raw, target_b;
    logic [7:0]       duty_a_next, duty_b_next;
    logic [9:0]       headroom;
    logic             over_budget;

    function automatic logic [7:0] clamp_target(input logic [7:0] req, input logic ok);
        if (!ok || (req == 8'd0))
            return 8'd0;
        else if (req < PWM_MIN)
            return PWM_MIN;
        else if (req > PWM_MAX)
            return PWM_MAX;
        else
            return req;
    endfunction

    assign tick = (div_cnt == DIV_LAST);

`ifdef PUMP_WDOG_EN
    logic fault_q, trip_a, trip_b;
    assign fault  = fault_q;
    assign permit = enable && !fault_q;
`else
    assign permit = enable;
`endif

    assign target_a     = clamp_target(req_duty_a, permit);
    assign target_b_raw = clamp_target(req_duty_b, permit);

    // B only gets what A leaves over after A's own step this cycle; scraps below PWM_MIN mean off.
    always_comb begin
        headroom = ({1'b0, BUDGET} > {2'b00, duty_a_next}) ?
                   ({1'b0, BUDGET} - {2'b00, duty_a_next}) : 10'd0;
        over_budget = (target_b_raw != 8'd0) && ({2'b00, target_b_raw} > headroom);
        target_b    = target_b_raw;
        if (over_budget)
            target_b = (headroom < {2'b00, PWM_MIN}) ? 8'd0 : headroom[7:0];
    end

    pump_channel #(
        .RAMP_STEP      (RAMP_STEP),
        .MIN_OFF_CYCLES (MIN_OFF_CYCLES),
        .PWM_MIN        (PWM_MIN)
`ifdef PUMP_WDOG_EN
        , .WDOG_CYCLES  (WDOG_CYCLES)
`endif
    ) u_pump_a (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .target    (target_a),
        .cut       (1'b0),
        .duty      (duty_a),
        .duty_next (duty_a_next),
        .running   (running_a)
`ifdef PUMP_WDOG_EN
        , .trip    (trip_a)
`endif
    );

    pump_channel #(
        .RAMP_STEP      (RAMP_STEP),
        .MIN_OFF_CYCLES (MIN_OFF_CYCLES),
        .PWM_MIN        (PWM_MIN)
`ifdef PUMP_WDOG_EN
        , .WDOG_CYCLES  (WDOG_CYCLES)
`endif
    ) u_pump_b (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .target    (target_b),
        .cut       (over_budget),
        .duty      (duty_b),
        .duty_next (duty_b_next),
        .running   (running_b)
`ifdef PUMP_WDOG_EN
        , .trip    (trip_b)
`endif
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt   <= '0;
            duty_a    <= 8'd0;
            duty_b    <= 8'd0;
            clipped_b <= 1'b0;
        end else begin
            div_cnt   <= tick ? '0 : div_cnt + DIV_W'(1);
            duty_a    <= duty_a_next;
            duty_b    <= duty_b_next;
            clipped_b <= over_budget;
        end
    end

`ifdef PUMP_WDOG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            fault_q <= 1'b0;
        else if (trip_a || trip_b)
            fault_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_pump_scheduler.sv
// Randomized scoreboard bench for pump_scheduler: a per-edge reference model queues expected
// outputs, a monitor compares them against the DUT after every clock edge.

module tb_pump_scheduler;

    localparam int RAMP_DIV = 4;
    localparam int MIN_OFF  = 20;
    localparam int BUDGET   = 300;
    localparam int PWM_MIN  = 77;
    localparam int PWM_MAX  = 230;
    localparam int STEP     = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] req_duty_a = 8'd0;
    logic [7:0] req_duty_b = 8'd0;
    logic [7:0] duty_a, duty_b;
    logic       running_a, running_b, clipped_b;
`ifdef PUMP_WDOG_EN
    logic       fault;
`endif

    always #5 clk = ~clk;

    pump_scheduler #(
        .RAMP_DIV       (RAMP_DIV),
        .RAMP_STEP      (8'd4),
        .MIN_OFF_CYCLES (MIN_OFF),
        .PWM_MIN        (8'd77),
        .PWM_MAX        (8'd230),
        .BUDGET         (9'd300)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_duty_a (req_duty_a),
        .req_duty_b (req_duty_b),
        .duty_a     (duty_a),
        .duty_b     (duty_b),
        .running_a  (running_a),
        .running_b  (running_b),
        .clipped_b  (clipped_b)
`ifdef PUMP_WDOG_EN
        , .fault    (fault)
`endif
    );

    typedef struct {
        int edge_no;
        int da;
        int db;
        bit ra;
        bit rb;
        bit cb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   edges_seen = 0;

    // Reference state: edges since reset, per-pump duty, on/running flags and restart time.
    int   m_n;
    int   m_duty[2];
    bit   m_on[2];
    bit   m_run[2];
    int   m_avail[2];
    bit   m_clip;

    always @(posedge clk) edges_seen <= edges_seen + 1;

    task automatic check_output(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edges_seen);
        end
    endtask

    function automatic int tgt_of(input int req, input bit en);
        if (!en || req == 0) return 0;
        if (req < PWM_MIN) return PWM_MIN;
        if (req > PWM_MAX) return PWM_MAX;
        return req;
    endfunction

    function automatic int toward(input int cur, input int tgt);
        int d;
        d = (tgt > cur) ? tgt - cur : cur - tgt;
        if (d > STEP) d = STEP;
        return (tgt > cur) ? cur + d : cur - d;
    endfunction

    task automatic model_reset();
        m_n = 0;
        m_clip = 0;
        for (int p = 0; p < 2; p++) begin
            m_duty[p] = 0;
            m_on[p] = 0;
            m_run[p] = 0;
            m_avail[p] = 0;
        end
    endtask

    task automatic model_pump(input int p, input int tgt, input bit cut, input bit tick);
        if (!m_on[p]) begin
            m_duty[p] = 0;
            m_run[p] = 0;
            if (tgt != 0 && m_n >= m_avail[p]) begin
                m_on[p] = 1;
                m_duty[p] = PWM_MIN;
            end
        end else if (tgt == 0) begin
            m_on[p] = 0;
            m_duty[p] = 0;
            m_run[p] = 0;
            m_avail[p] = m_n + MIN_OFF + 1;
        end else if (cut && m_duty[p] > tgt) begin
            m_duty[p] = tgt;
            m_run[p] = 1;
        end else if (m_run[p]) begin
            if (m_duty[p] != tgt) m_run[p] = 0;
        end else if (m_duty[p] == tgt) begin
            m_run[p] = 1;
        end else if (tick) begin
            m_duty[p] = toward(m_duty[p], tgt);
            m_run[p] = (m_duty[p] == tgt);
        end
    endtask

    // Called just after a falling edge; each iteration predicts the next rising edge.
    task automatic apply_stimulus(input bit en, input int ra, input int rb, input int cycles);
        exp_t e;
        int   head, tb_tgt;
        bit   tick;
        for (int i = 0; i < cycles; i++) begin
            enable = en;
            req_duty_a = 8'(ra);
            req_duty_b = 8'(rb);
            m_n++;
            tick = ((m_n % RAMP_DIV) == 0);
            model_pump(0, tgt_of(ra, en), 1'b0, tick);
            head = BUDGET - m_duty[0];
            tb_tgt = tgt_of(rb, en);
            m_clip = (tb_tgt != 0) && (tb_tgt > head);
            if (m_clip) tb_tgt = (head < PWM_MIN) ? 0 : head;
            model_pump(1, tb_tgt, m_clip, tick);
            e.edge_no = edges_seen + 1;
            e.da = m_duty[0];
            e.db = m_duty[1];
            e.ra = m_run[0];
            e.rb = m_run[1];
            e.cb = m_clip;
            sb.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic reset_pulse();
        #2;
        reset = 1'b0;
        #1;
        check_output("reset_duty_a", {1'b0, duty_a}, 9'd0);
        check_output("reset_duty_b", {1'b0, duty_b}, 9'd0);
        check_output("reset_running_a", {8'd0, running_a}, 9'd0);
        check_output("reset_running_b", {8'd0, running_b}, 9'd0);
        check_output("reset_clipped_b", {8'd0, clipped_b}, 9'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    function automatic int rand_req();
        case ($urandom_range(0, 3))
            0: return 0;
            1: return int'($urandom_range(1, 76));
            2: return int'($urandom_range(77, 230));
            default: return int'($urandom_range(231, 255));
        endcase
    endfunction

    // Monitor: after each edge, pop every expectation whose edge has passed and compare.
    initial begin
        exp_t e;
        int   sum;
        forever begin
            @(negedge clk);
            #1;
            while (sb.size() > 0 && sb[0].edge_no <= edges_seen) begin
                e = sb.pop_front();
                check_output("duty_a", {1'b0, duty_a}, 9'(e.da));
                check_output("duty_b", {1'b0, duty_b}, 9'(e.db));
                check_output("running_a", {8'd0, running_a}, {8'd0, e.ra});
                check_output("running_b", {8'd0, running_b}, {8'd0, e.rb});
                check_output("clipped_b", {8'd0, clipped_b}, {8'd0, e.cb});
                sum = int'(duty_a) + int'(duty_b);
                check_output("budget_sum", (sum <= BUDGET) ? 9'd1 : 9'd0, 9'd1);
            end
        end
    end

    initial begin
        #400_000;
        $display("[TB] FAIL timeout: simulation did not complete, edges=%0d", edges_seen);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        bit en;
        int ra, rb, len;
        model_reset();
        #2;
        reset = 1'b0;
        #2;
        check_output("por_duty_a", {1'b0, duty_a}, 9'd0);
        check_output("por_duty_b", {1'b0, duty_b}, 9'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Soft start to 150, clamp low/high, budget sharing, A stop releases B.
        apply_stimulus(1, 150, 0, 90);
        apply_stimulus(1, 20, 0, 90);
        apply_stimulus(1, 255, 0, 170);
        apply_stimulus(1, 200, 0, 40);
        apply_stimulus(1, 200, 150, 60);
        apply_stimulus(1, 0, 150, 70);
        // A rising against a running B, then holdoff with an early re-request.
        apply_stimulus(1, 150, 150, 90);
        apply_stimulus(1, 150, 0, 10);
        apply_stimulus(1, 0, 0, 5);
        apply_stimulus(1, 150, 0, 40);
        // Global disable drops both pumps into holdoff.
        apply_stimulus(1, 180, 120, 60);
        apply_stimulus(0, 180, 120, 30);
        // Reset mid-ramp, request held across release.
        apply_stimulus(1, 150, 0, 18);
        reset_pulse();
        apply_stimulus(1, 150, 0, 12);

        for (int ph = 0; ph < 30; ph++) begin
            en = ($urandom_range(0, 9) != 0);
            ra = rand_req();
            rb = rand_req();
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(20, 120));
            apply_stimulus(en, ra, rb, len);
            if (ph == 15) reset_pulse();
        end

        repeat (3) @(negedge clk);
        #2;
        check_output("scoreboard_drained", 9'(sb.size()), 9'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pump_scheduler.md
Name: pump_scheduler

Overview:
Sequences the two filter pumps between the filter FSM and the PWM generator. Takes raw duty requests for pump A (fill) and pump B (drain) and applies soft-start ramping, minimum-off (dry-run/restart) protection, clamping to the PWM range and a shared power budget with pump A priority. Outputs are registered duty values that drive the PWM generator directly.

Parameters:
RAMP_DIV, 500_000, clk cycles per ramp tick (10 ms @ 50 MHz)
RAMP_STEP, 8'd4, max duty change per ramp tick
MIN_OFF_CYCLES, 50_000_000, forced off time after a pump stops (1 s)
PWM_MIN, 8'd77, lowest nonzero duty
PWM_MAX, 8'd230, highest duty
BUDGET, 9'd400, max allowed duty_a + duty_b
WDOG_CYCLES, 32'd2_500_000_000, max continuous on-time per pump (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  global run permission
req_duty_a  in  8  requested duty, pump A; 0 = off
req_duty_b  in  8  requested duty, pump B; 0 = off
duty_a  out  8  scheduled duty to PWM generator, pump A
duty_b  out  8  scheduled duty to PWM generator, pump B
running_a  out  1  pump A in RUN (duty_a == target)
running_b  out  1  pump B in RUN
clipped_b  out  1  pump B target reduced by budget this cycle
fault  out  1  watchdog trip (present only with PUMP_WDOG_EN)

Behaviour:
- Reset (async, active-low): duty_a=duty_b=0, running_*=0, clipped_b=0, fault=0, both FSMs OFF, ramp divider=0, holdoff counters=0. Release goes to OFF with no holdoff.
- Ramp tick: free-running divider; 1-cycle pulse every RAMP_DIV cycles; shared by both pumps.
- Target: req==0 or enable==0 -> 0; else clamp req to [PWM_MIN, PWM_MAX].
- Budget: B target = min(target_b, BUDGET - duty_a_next), where duty_a_next is A's next-state value (same cycle). If that headroom < PWM_MIN, B target = 0. clipped_b=1 whenever the budget reduced B's target. Invariant: duty_a + duty_b <= BUDGET every cycle.
- Per-pump FSM (identical, independent):
  OFF: duty 0. target != 0 -> RAMP, duty = PWM_MIN on that edge (1-cycle latency).
  RAMP: on each tick, duty moves toward target by min(RAMP_STEP, |target - duty|), no overshoot. duty == target -> RUN. target == 0 -> duty 0 immediately, HOLDOFF.
  RUN: running=1. target != duty -> RAMP. target == 0 -> duty 0, HOLDOFF.
  HOLDOFF: duty 0, requests ignored, counts MIN_OFF_CYCLES, then OFF.
- Exception: B budget reduction is applied on the same edge, not ramped. Only rises and non-budget falls are ramped.
- enable falling: both running pumps drop to 0 on the next edge and enter HOLDOFF.
- Simultaneous A rise and B request: A is scheduled first; B sees the post-step headroom.
- Counter widths are sized for the parameter defaults. Holdoff and divider counters must not wrap.

Optional Feature:
PUMP_WDOG_EN: defined -> per-pump on-time counter, cleared in OFF/HOLDOFF. When it reaches WDOG_CYCLES, that pump is forced to 0 and HOLDOFF, and fault latches to 1. fault clears only on reset. While fault=1, both targets are 0. Undefined -> no counters, fault port absent, behaviour otherwise identical.

Test Plan:
(Sim parameters RAMP_DIV=4, MIN_OFF_CYCLES=20, BUDGET=300.)
- Reset then enable=1, req_duty_a=150 -> duty_a=77 one edge later. Increases +4 per tick (81, 85, ...), last step +1 to 150. running_a=1 at 150. duty_b stays 0.
- req_duty_a=20 -> target 77. req_duty_a=255 -> duty_a ramps to 230 and stops; never exceeds 230.
- A at 200 steady, req_duty_b=150 -> duty_b ramps 77..100 and holds; clipped_b=1; sum=300. Drop req_a to 0 -> clipped_b=0 and B ramps 100 to 150.
- A at 150, req_duty_a=0 -> duty_a=0 next edge. req_duty_a=150 reasserted 5 cycles later -> duty_a stays 0 until 20 cycles after the stop, then 77.
- Assert reset mid-ramp (duty_a=93) between clock edges -> duty_a=0 immediately. After release with req held -> 77 on the first edge, no holdoff.
- With PUMP_WDOG_EN, WDOG_CYCLES=50, A held at 150 -> at cycle 50 duty_a=0 and fault=1. fault stays 1 and both duties stay 0 until reset.
